// File: rtl/sens_event_pkg.sv
// sens_event_pkg
// Shared definitions for the sensitivity event-capture slice:
//   - default geometry (width of the monitored group, FIFO depth, timestamp width)
//   - sens_event_t: one captured event {mask, value, tstamp} at default geometry
//   - cnt_w(): width of an occupancy counter able to hold 0..depth
package sens_event_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_TS_W  = 8;

    // Field order matches the parameterised entry built inside the top module,
    // so a packed event is {mask, value, tstamp} from MSB to LSB everywhere.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] mask;
        logic [DEF_WIDTH-1:0] value;
        logic [DEF_TS_W-1:0]  tstamp;
    } sens_event_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sens_event_capture_if.sv
// sens_event_capture_if
// Event drain handshake between the capture stage and its consumer.
//   ev_valid : head event available          (capture -> consumer)
//   ev_ready : consumer accepts head event   (consumer -> capture)
//   ev_mask  : bits that changed
//   ev_value : monitored value after the change
//   ev_time  : timestamp of the capturing edge
// master = capture stage, slave = consumer.
interface sens_event_capture_if
    import sens_event_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TS_W  = DEF_TS_W
);
    logic             ev_valid;
    logic             ev_ready;
    logic [WIDTH-1:0] ev_mask;
    logic [WIDTH-1:0] ev_value;
    logic [TS_W-1:0]  ev_time;

    modport master (
        output ev_valid, ev_mask, ev_value, ev_time,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_mask, ev_value, ev_time,
        output ev_ready
    );

endinterface

// File: rtl/sens_event_fifo.sv
// sens_event_fifo
// Synchronous FIFO for packed event entries.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write wdata (ignored when full unless a pop happens on the same edge)
//   pop      : drop the head entry (ignored when empty)
//   wdata    : entry to write
//   rdata    : head entry, zero when empty
//   full, empty, count : occupancy status
module sens_event_fifo
    import sens_event_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = DEF_DEPTH
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    // Extra MSB is the wrap bit: equal index with different wrap bit means full.
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, the slot being vacated by the pop is the one written.
    assign do_push = push && (!full || do_pop);
    assign count   = wptr - rptr;
    assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: empty masks stale contents.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sens_event_capture.sv
// sens_event_capture
// Samples a combinational signal group every clock and queues each change as a
// timestamped event {changed mask, new value, time} for a downstream consumer.
//   clk, rst : clock, synchronous active-high reset
//   sig_in   : monitored signal group
//   en       : capture enable (changes while low are absorbed, never reported)
//   clr_ovf  : clears the sticky overflow flag (a drop on the same edge wins)
//   ev       : event drain handshake (master side)
//   count    : entries held
//   overflow : sticky, an event was dropped because the FIFO was full
module sens_event_capture
    import sens_event_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int TS_W  = DEF_TS_W
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         sig_in,
    input  logic                     en,
    input  logic                     clr_ovf,
    sens_event_capture_if.master     ev,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     overflow
);
    typedef struct packed {
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] value;
        logic [TS_W-1:0]  tstamp;
    } ev_t;

    logic [WIDTH-1:0] prev;
    logic             armed;
    logic [TS_W-1:0]  ts;
    ev_t              wentry;
    ev_t              head;
    logic             full;
    logic             empty;
    logic             change;
    logic             pop;
    logic             push;
    logic             drop;

    // armed holds off the first edge so the reset value of prev never
    // looks like a change.
    assign change = armed && en && (sig_in != prev);
    assign pop    = !empty && ev.ev_ready;
    assign push   = change && (!full || pop);
    assign drop   = change && full && !pop;

    assign wentry.mask   = sig_in ^ prev;
    assign wentry.value  = sig_in;
    assign wentry.tstamp = ts;

    sens_event_fifo #(
        .DATA_W ($bits(ev_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '0;
            armed    <= 1'b0;
            ts       <= '0;
            overflow <= 1'b0;
        end else begin
            prev  <= sig_in;
            armed <= 1'b1;
            ts    <= ts + 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign ev.ev_valid = !empty;
    assign ev.ev_mask  = head.mask;
    assign ev.ev_value = head.value;
    assign ev.ev_time  = head.tstamp;

endmodule

// File: tb/tb_sens_event_capture.sv
module tb_sens_event_capture;
    localparam int W  = 4;
    localparam int D  = 4;
    localparam int T  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  sig_in;
    logic          en;
    logic          clr_ovf;
    logic [CW-1:0] count;
    logic          overflow;

    always #5 clk = ~clk;

    sens_event_capture_if #(.WIDTH(W), .TS_W(T)) ev_if ();

    sens_event_capture #(.WIDTH(W), .DEPTH(D), .TS_W(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .en       (en),
        .clr_ovf  (clr_ovf),
        .ev       (ev_if),
        .count    (count),
        .overflow (overflow)
    );

    // Reference model: an event log kept as a queue with a capacity limit.
    typedef struct {
        int mask;
        int value;
        int t;
    } mev_t;

    mev_t q[$];
    int   m_prev;
    bit   m_armed;
    int   m_ts;
    bit   m_ovf;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input int s, input logic e, input logic rdy, input logic co);
        bit   pop, full, evt, drop;
        mev_t n;
        if (r) begin
            q.delete();
            m_prev  = 0;
            m_armed = 0;
            m_ts    = 0;
            m_ovf   = 0;
        end else begin
            pop  = (q.size() > 0) && rdy;
            full = (q.size() == D);
            evt  = m_armed && e && (s != m_prev);
            drop = evt && full && !pop;
            if (pop) void'(q.pop_front());
            if (evt && !drop) begin
                n.mask  = s ^ m_prev;
                n.value = s;
                n.t     = m_ts;
                q.push_back(n);
            end
            if (drop)    m_ovf = 1;
            else if (co) m_ovf = 0;
            m_prev  = s;
            m_armed = 1;
            m_ts    = (m_ts + 1) % (1 << T);
        end
    endtask

    task automatic compare();
        bit ne;
        ne = q.size() > 0;
        chk("valid", 32'(ev_if.ev_valid), 32'(ne));
        chk("mask",  32'(ev_if.ev_mask),  ne ? q[0].mask  : 0);
        chk("value", 32'(ev_if.ev_value), ne ? q[0].value : 0);
        chk("time",  32'(ev_if.ev_time),  ne ? q[0].t     : 0);
        chk("count", 32'(count),          q.size());
        chk("ovf",   32'(overflow),       32'(m_ovf));
    endtask

    // One clock: drive inputs, let the edge happen, advance model, check.
    task automatic cycle(input logic r, input logic [W-1:0] s, input logic e,
                         input logic rdy, input logic co);
        rst = r; sig_in = s; en = e; ev_if.ev_ready = rdy; clr_ovf = co;
        @(posedge clk);
        model_step(r, int'(s), e, rdy, co);
        #1;
        compare();
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * D; i++) begin
            if (q.size() == 0) break;
            cycle(1'b0, sig_in, 1'b1, 1'b1, 1'b0);
        end
        chk("drain_cnt", 32'(count), 0);
    endtask

    initial begin
        logic [W-1:0] s;
        int n;
        rst = 1'b1; sig_in = '0; en = 1'b1; clr_ovf = 1'b0; ev_if.ev_ready = 1'b0;
        q.delete(); m_prev = 0; m_armed = 0; m_ts = 0; m_ovf = 0;

        // Reset arming
        cycle(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
        chk("rst_valid", 32'(ev_if.ev_valid), 0);
        chk("rst_count", 32'(count), 0);
        cycle(1'b0, 4'b1010, 1'b1, 1'b0, 1'b0);
        chk("arm_noev", 32'(ev_if.ev_valid), 0);
        cycle(1'b0, 4'b1010, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'b1011, 1'b1, 1'b0, 1'b0);
        chk("arm_mask",  32'(ev_if.ev_mask),  32'h1);
        chk("arm_value", 32'(ev_if.ev_value), 32'hb);
        chk("arm_time",  32'(ev_if.ev_time),  2);
        drain();

        // Multi-bit change with ready held low
        cycle(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        drain();
        cycle(1'b0, 4'b0110, 1'b1, 1'b0, 1'b0);
        chk("multi_mask", 32'(ev_if.ev_mask), 32'h6);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b0110, 1'b1, 1'b0, 1'b0);
            chk("hold_mask",  32'(ev_if.ev_mask),  32'h6);
            chk("hold_value", 32'(ev_if.ev_value), 32'h6);
            chk("hold_count", 32'(count), 1);
        end
        drain();

        // Enable gating
        cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'hf, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'h3, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 4'h3, 1'b1, 1'b1, 1'b0);
        chk("gate_count", 32'(count), 0);
        cycle(1'b0, 4'h7, 1'b1, 1'b0, 1'b0);
        chk("gate_mask", 32'(ev_if.ev_mask), 32'h4);
        drain();

        // Overflow: six changes with ready low
        for (int i = 0; i < 6; i++) cycle(1'b0, W'(8 + i), 1'b1, 1'b0, 1'b0);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_flag",  32'(overflow), 1);
        chk("ovf_head",  32'(ev_if.ev_value), 32'h8);
        cycle(1'b0, 4'he, 1'b1, 1'b0, 1'b1);
        chk("ovf_setwins", 32'(overflow), 1);
        cycle(1'b0, 4'he, 1'b1, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 0);
        // Full with simultaneous push and pop
        cycle(1'b0, 4'hf, 1'b1, 1'b1, 1'b0);
        chk("fullpp_count", 32'(count), 4);
        chk("fullpp_ovf",   32'(overflow), 0);
        chk("fullpp_head",  32'(ev_if.ev_value), 32'h9);
        drain();

        // Timestamp wrap, then reset with events queued
        cycle(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (m_ts != 15 && n < 40) begin
            cycle(1'b0, 4'h5, 1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("ts_reach15", 32'(n < 40), 1);
        cycle(1'b0, 4'h4, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'h4, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'hc, 1'b1, 1'b0, 1'b0);
        chk("wrap_count", 32'(count), 2);
        chk("wrap_t15",   32'(ev_if.ev_time), 15);
        cycle(1'b0, 4'hc, 1'b1, 1'b1, 1'b0);
        chk("wrap_t1",    32'(ev_if.ev_time), 1);
        cycle(1'b0, 4'hd, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'hf, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 3);
        cycle(1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_valid", 32'(ev_if.ev_valid), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 2) == 0) ? W'($urandom) : sig_in;
            cycle(($urandom_range(0, 99) == 0),
                  s,
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) == 0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
